output_link_ctrl: RTL and testbench
===================================

Name: output_link_ctrl

Overview:
- Output-side stage of a router port: registers the flit leaving the crossbar and drives it onto the link to the downstream router's input port (data/valid pair).
- Keeps credit-based flow control with one credit counter per downstream VC; each counter starts at the downstream buffer depth.
- Reports per-VC credit availability to the switch allocator and per-VC idle status to the VC allocator.
- Types (flit_t, vc_id, flit_label HEAD/BODY/TAIL/HEADTAIL) and VC_NUM come from noc_params.

Parameters:
BUFFER_SIZE, 8, depth of each downstream input VC buffer; also the reset value of every credit counter
CREDIT_W, $clog2(BUFFER_SIZE+1), credit counter width; derived, not overridden

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
data_i  input  flit_t  flit from crossbar; data_i.vc_id is the downstream VC
valid_flit_i  input  1  data_i valid this cycle
credit_i  input  1  downstream freed one buffer slot this cycle
credit_vc_i  input  $clog2(VC_NUM)  VC the returned credit belongs to
data_o  output  flit_t  registered flit to downstream input port
valid_flit_o  output  1  data_o valid
has_credit_o  output  VC_NUM  bit v = credit count of VC v is non-zero
vc_idle_o  output  VC_NUM  bit v = VC v has no open packet and a full credit count
error_o  output  1  sticky protocol-violation flag

Behaviour:
- Single clock domain; all state updates on the rising edge of clk. Synchronous active-high reset.
- Reset values:
  - credit[v] = BUFFER_SIZE; open[v] = 0 for all v.
  - data_o = 0; valid_flit_o = 0; error_o = 0.
  - Outputs after reset: has_credit_o = all 1s; vc_idle_o = all 1s.
- Reset wins over any same-cycle valid_flit_i or credit_i. Reset mid-packet discards the in-flight flit and open state.
- Send (s = valid_flit_i, v = data_i.vc_id):
  - If credit[v] != 0: next cycle data_o = data_i and valid_flit_o = 1. Latency is exactly 1 cycle; no bubbles on back-to-back sends.
  - If credit[v] == 0: the flit is dropped, valid_flit_o = 0 next cycle, error_o set.
- When no send is accepted, valid_flit_o = 0 next cycle and data_o holds its last value.
- Credit counter per VC:
  - Accepted send only: credit - 1. Credit return only: credit + 1.
  - Accepted send and credit return on the same VC in the same cycle: unchanged.
  - Send and credit on different VCs: each updated independently.
  - Credit return while credit == BUFFER_SIZE (overflow), with no accepted send on that VC: ignored, error_o set.
  - A credit arriving in the same cycle as a dropped send on the same VC still increments.
- Packet tracking (open[v]), updated only on accepted sends:
  - HEAD sets open[v]; TAIL clears it; HEADTAIL and BODY leave it unchanged.
  - HEAD while open[v] = 1: error_o set, open stays 1.
  - BODY or TAIL while open[v] = 0: error_o set, open stays 0.
- Status outputs:
  - has_credit_o[v] = (credit[v] != 0), combinational from registered state only. It does not anticipate same-cycle sends or credits.
  - vc_idle_o[v] = !open[v] && credit[v] == BUFFER_SIZE, combinational from registered state.
- error_o is sticky until rst. It never blocks legal traffic.

Test Plan:
- Reset then HEAD on VC0 at cycle 1 -> data_o = that flit, valid_flit_o = 1 at cycle 2; credit[0] = 7; vc_idle_o[0] = 0; has_credit_o = all 1s.
- 8 back-to-back BODY/TAIL flits on VC1 (HEAD first, no credits) -> valid_flit_o high 8 consecutive cycles; has_credit_o[1] = 0 after the 8th. A 9th flit is dropped: valid_flit_o = 0, error_o = 1.
- credit[2] = 3; same cycle valid send on VC2 and credit_i with credit_vc_i = 2 -> credit[2] stays 3, flit forwarded, error_o = 0.
- HEADTAIL on VC3, then 1 credit returned on VC3 -> vc_idle_o[3] = 0 for the cycle after the send, back to 1 the cycle after the credit.
- credit_i on VC0 immediately after reset -> error_o = 1, credit[0] stays 8. A following legal HEAD on VC0 is still forwarded.
- rst asserted mid-packet on VC1 (open, credit = 5) together with valid_flit_i -> next cycle valid_flit_o = 0, vc_idle_o = all 1s, error_o = 0.

Source files
------------

// File: rtl/noc_params.sv
// Shared NoC types: flit layout, flit labels and the VC count used by router port stages.
package noc_params;

  localparam int VC_NUM = 4;
  localparam int VC_W   = $clog2(VC_NUM);
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef logic [VC_W-1:0] vc_id_t;

  typedef struct packed {
    flit_label_t         flit_label;
    vc_id_t              vc_id;
    logic [DATA_W-1:0]   data;
  } flit_t;

endpackage

// File: rtl/output_link_ctrl.sv
// Output stage of a router port: registers the crossbar flit onto the link and
// keeps per-VC credit counts and packet-open state for the downstream input buffers.
module output_link_ctrl
  import noc_params::*;
#(
  parameter  int BUFFER_SIZE = 8,
  localparam int CREDIT_W    = $clog2(BUFFER_SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  flit_t             data_i,
  input  logic              valid_flit_i,
  input  logic              credit_i,
  input  logic [VC_W-1:0]   credit_vc_i,
  output flit_t             data_o,
  output logic              valid_flit_o,
  output logic [VC_NUM-1:0] has_credit_o,
  output logic [VC_NUM-1:0] vc_idle_o,
  output logic              error_o
);

  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(BUFFER_SIZE);
  localparam logic [CREDIT_W-1:0] ONE  = CREDIT_W'(1);

  logic [VC_NUM-1:0] accept;
  logic [VC_NUM-1:0] err_vc;

  flit_t data_q;
  logic  valid_q;
  logic  error_q;

  generate
    for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
      localparam vc_id_t VC = vc_id_t'(gi);

      logic [CREDIT_W-1:0] credit_q, credit_d;
      logic                open_q, open_d;
      logic                send_hit, cred_hit, accept_l, overflow, proto_err;

      assign send_hit = valid_flit_i && (data_i.vc_id == VC);
      assign cred_hit = credit_i && (credit_vc_i == VC);
      assign accept_l = send_hit && (credit_q != '0);
      // A credit beyond the buffer depth is meaningless unless a send consumes one this cycle.
      assign overflow = cred_hit && !accept_l && (credit_q == FULL);

      always_comb begin
        credit_d = credit_q;
        if (accept_l && !cred_hit) begin
          credit_d = credit_q - ONE;
        end else if (cred_hit && !accept_l && (credit_q != FULL)) begin
          credit_d = credit_q + ONE;
        end
      end

      always_comb begin
        open_d    = open_q;
        proto_err = 1'b0;
        if (accept_l) begin
          case (data_i.flit_label)
            HEAD: begin
              proto_err = open_q;
              open_d    = 1'b1;
            end
            TAIL: begin
              proto_err = !open_q;
              open_d    = 1'b0;
            end
            BODY:    proto_err = !open_q;
            default: proto_err = 1'b0;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          credit_q <= FULL;
          open_q   <= 1'b0;
        end else begin
          credit_q <= credit_d;
          open_q   <= open_d;
        end
      end

      assign accept[gi]       = accept_l;
      assign err_vc[gi]       = (send_hit && !accept_l) || overflow || proto_err;
      assign has_credit_o[gi] = (credit_q != '0);
      assign vc_idle_o[gi]    = !open_q && (credit_q == FULL);
    end
  endgenerate

  // data_q only loads on an accepted send so the link holds its last flit while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= |accept;
      if (|accept) begin
        data_q <= data_i;
      end
      if (|err_vc) begin
        error_q <= 1'b1;
      end
    end
  end

  assign data_o       = data_q;
  assign valid_flit_o = valid_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_output_link_ctrl.sv
// Directed table-driven bench for output_link_ctrl with hand sequences for credit corner cases.
module tb_output_link_ctrl;
  import noc_params::*;

  logic              clk = 1'b0;
  logic              rst;
  flit_t             data_i;
  logic              valid_flit_i;
  logic              credit_i;
  logic [VC_W-1:0]   credit_vc_i;
  flit_t             data_o;
  logic              valid_flit_o;
  logic [VC_NUM-1:0] has_credit_o;
  logic [VC_NUM-1:0] vc_idle_o;
  logic              error_o;

  always #5 clk = ~clk;

  output_link_ctrl #(.BUFFER_SIZE(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_flit_i (valid_flit_i),
    .credit_i     (credit_i),
    .credit_vc_i  (credit_vc_i),
    .data_o       (data_o),
    .valid_flit_o (valid_flit_o),
    .has_credit_o (has_credit_o),
    .vc_idle_o    (vc_idle_o),
    .error_o      (error_o)
  );

  typedef struct {
    string             name;
    logic              r;
    logic              v;
    flit_t             f;
    logic              c;
    int                cvc;
    logic              e_vld;
    flit_t             e_data;
    logic [VC_NUM-1:0] e_hc;
    logic [VC_NUM-1:0] e_idle;
    logic              e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic flit_t mk(flit_label_t l, int vc, logic [15:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = VC_W'(vc);
    f.data       = d;
    return f;
  endfunction

  task automatic add(input string name, input logic r, input logic v, input flit_t f,
                     input logic c, input int cvc, input logic ev, input flit_t ed,
                     input logic [VC_NUM-1:0] hc, input logic [VC_NUM-1:0] idle,
                     input logic err);
    vec_t x;
    x.name = name; x.r = r; x.v = v; x.f = f; x.c = c; x.cvc = cvc;
    x.e_vld = ev; x.e_data = ed; x.e_hc = hc; x.e_idle = idle; x.e_err = err;
    vecs.push_back(x);
  endtask

  task automatic apply(input logic r, input logic v, input flit_t f, input logic c, input int cvc);
    rst          = r;
    valid_flit_i = v;
    data_i       = f;
    credit_i     = c;
    credit_vc_i  = VC_W'(cvc);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input flit_t ed,
                       input logic [VC_NUM-1:0] hc, input logic [VC_NUM-1:0] idle,
                       input logic err);
    n_checks++;
    if (valid_flit_o === ev && data_o === ed && has_credit_o === hc &&
        vc_idle_o === idle && error_o === err) begin
      n_pass++;
      $display("ok   %s: valid=%b data=%h hc=%b idle=%b err=%b",
               name, valid_flit_o, data_o, has_credit_o, vc_idle_o, error_o);
    end else begin
      $display("FAIL %s: got valid=%b data=%h hc=%b idle=%b err=%b, expected valid=%b data=%h hc=%b idle=%b err=%b",
               name, valid_flit_o, data_o, has_credit_o, vc_idle_o, error_o,
               ev, ed, hc, idle, err);
    end
  endtask

  initial begin
    flit_t z, f, last;
    z = '0;
    rst = 1'b1; valid_flit_i = 1'b0; data_i = '0; credit_i = 1'b0; credit_vc_i = '0;

    // Reset, HEAD/TAIL on VC0 with credit returns.
    add("reset",          1, 0, z, 0, 0, 0, z, 4'hF, 4'hF, 0);
    f = mk(HEAD, 0, 16'hA001);
    add("head_vc0",       0, 1, f, 0, 0, 1, f, 4'hF, 4'hE, 0);
    add("credit_vc0_open",0, 0, z, 1, 0, 0, f, 4'hF, 4'hE, 0);
    f = mk(TAIL, 0, 16'hA002);
    add("tail_vc0",       0, 1, f, 0, 0, 1, f, 4'hF, 4'hE, 0);
    add("credit_vc0_done",0, 0, z, 1, 0, 0, f, 4'hF, 4'hF, 0);
    // Eight back-to-back flits on VC1 exhaust its credits; the ninth is dropped.
    f = mk(HEAD, 1, 16'hB000);
    add("vc1_flit0",      0, 1, f, 0, 0, 1, f, 4'hF, 4'hD, 0);
    for (int i = 1; i <= 6; i++) begin
      f = mk(BODY, 1, 16'hB000 + 16'(i));
      add($sformatf("vc1_flit%0d", i), 0, 1, f, 0, 0, 1, f, 4'hF, 4'hD, 0);
    end
    f = mk(TAIL, 1, 16'hB007);
    add("vc1_flit7",      0, 1, f, 0, 0, 1, f, 4'hD, 4'hD, 0);
    last = f;
    f = mk(HEAD, 1, 16'hB008);
    add("vc1_drop",       0, 1, f, 0, 0, 0, last, 4'hD, 4'hD, 1);
    // HEADTAIL on VC3 leaves it non-idle until the credit returns.
    f = mk(HEADTAIL, 3, 16'hC000);
    add("headtail_vc3",   0, 1, f, 0, 0, 1, f, 4'hD, 4'h5, 1);
    add("credit_vc3",     0, 0, z, 1, 3, 0, f, 4'hD, 4'hD, 1);
    // Overflow right after reset, then legal traffic still flows.
    add("reset2",         1, 0, z, 0, 0, 0, z, 4'hF, 4'hF, 0);
    add("overflow_vc0",   0, 0, z, 1, 0, 0, z, 4'hF, 4'hF, 1);
    f = mk(HEAD, 0, 16'hD000);
    add("head_after_ovf", 0, 1, f, 0, 0, 1, f, 4'hF, 4'hE, 1);
    f = mk(BODY, 0, 16'hD001);
    add("send_credit_same",0,1, f, 1, 0, 1, f, 4'hF, 4'hE, 1);
    f = mk(TAIL, 0, 16'hD002);
    add("tail_vc0_b",     0, 1, f, 0, 0, 1, f, 4'hF, 4'hE, 1);
    add("credit_vc0_a",   0, 0, z, 1, 0, 0, f, 4'hF, 4'hE, 1);
    add("credit_vc0_b",   0, 0, z, 1, 0, 0, f, 4'hF, 4'hF, 1);
    // Reset mid-packet on VC1 with a same-cycle send.
    add("reset3",         1, 0, z, 0, 0, 0, z, 4'hF, 4'hF, 0);
    add("ovf_pre",        0, 0, z, 1, 2, 0, z, 4'hF, 4'hF, 1);
    f = mk(HEAD, 1, 16'hE000);
    add("mid_head_vc1",   0, 1, f, 0, 0, 1, f, 4'hF, 4'hD, 1);
    f = mk(BODY, 1, 16'hE001);
    add("mid_body1_vc1",  0, 1, f, 0, 0, 1, f, 4'hF, 4'hD, 1);
    f = mk(BODY, 1, 16'hE002);
    add("mid_body2_vc1",  0, 1, f, 0, 0, 1, f, 4'hF, 4'hD, 1);
    f = mk(BODY, 1, 16'hE003);
    add("rst_mid_pkt",    1, 1, f, 0, 0, 0, z, 4'hF, 4'hF, 0);
    // Send and credit on different VCs in the same cycle.
    f = mk(HEAD, 2, 16'hF000);
    add("head_vc2",       0, 1, f, 0, 0, 1, f, 4'hF, 4'hB, 0);
    f = mk(HEADTAIL, 0, 16'hF001);
    add("ht_vc0_cr_vc2",  0, 1, f, 1, 2, 1, f, 4'hF, 4'hA, 0);
    f = mk(TAIL, 2, 16'hF002);
    add("tail_vc2_cr_vc0",0, 1, f, 1, 0, 1, f, 4'hF, 4'hB, 0);
    add("credit_vc2",     0, 0, z, 1, 2, 0, f, 4'hF, 4'hF, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].v, vecs[i].f, vecs[i].c, vecs[i].cvc);
      check(vecs[i].name, vecs[i].e_vld, vecs[i].e_data, vecs[i].e_hc, vecs[i].e_idle, vecs[i].e_err);
    end

    // Bring VC2 to 3 credits, then a same-cycle send and credit must leave it at 3.
    apply(1, 0, z, 0, 0);
    check("seq3_reset", 0, z, 4'hF, 4'hF, 0);
    f = mk(HEAD, 2, 16'h3000);
    apply(0, 1, f, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      f = mk(BODY, 2, 16'h3000 + 16'(i));
      apply(0, 1, f, 0, 0);
    end
    check("seq3_credit3", 1, f, 4'hF, 4'hB, 0);
    f = mk(BODY, 2, 16'h3010);
    apply(0, 1, f, 1, 2);
    check("seq3_send_credit", 1, f, 4'hF, 4'hB, 0);
    for (int i = 1; i <= 3; i++) begin
      f = mk(BODY, 2, 16'h3020 + 16'(i));
      apply(0, 1, f, 0, 0);
      check($sformatf("seq3_drain%0d", i), 1, f, (i == 3) ? 4'hB : 4'hF, 4'hB, 0);
    end
    last = f;
    f = mk(TAIL, 2, 16'h3030);
    apply(0, 1, f, 0, 0);
    check("seq3_drop", 0, last, 4'hB, 4'hB, 1);

    // Out-of-packet BODY is flagged but still forwarded.
    apply(1, 0, z, 0, 0);
    f = mk(BODY, 0, 16'h4000);
    apply(0, 1, f, 0, 0);
    check("body_no_head", 1, f, 4'hF, 4'hE, 1);
    apply(0, 0, z, 0, 0);
    check("idle_after_body", 0, f, 4'hF, 4'hE, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
